// File: rtl/bcd_conv_sched.sv
// Two-requester sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Optional 7-segment output HEX_BUS enabled by defining BCD_CONV_SEG7_EN.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and captures the operand
// SHIFT  | add-3 adjust then shift, one operand bit per clock
// DONE   | result registered; ACK of the granted requester is high
module bcd_conv_sched #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RST_N,
  input  logic                  REQ0,
  input  logic [BIN_W-1:0]      BIN0,
  input  logic                  REQ1,
  input  logic [BIN_W-1:0]      BIN1,
  output logic                  ACK0,
  output logic                  ACK1,
  output logic                  OWNER,
  output logic                  BUSY,
  output logic [4*DIGITS-1:0]   BCD_OUT
`ifdef BCD_CONV_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   HEX_BUS
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               win_q, win_d;
  logic               last_q, last_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               owner_q, owner_d;

  logic [BCD_W-1:0]         adj;
  logic [BCD_W+BIN_W-1:0]   shv;
  logic                     gnt_any;
  logic                     gnt_sel;

  always_comb begin
    adj = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
    end
    shv = {adj, sh_q} << 1;
  end

  // With both requests high, the requester that was not served last wins.
  assign gnt_any = REQ0 | REQ1;
  assign gnt_sel = (REQ0 & REQ1) ? ~last_q : REQ1;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    last_d  = last_q;
    bcd_d   = bcd_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          sh_d    = gnt_sel ? BIN1 : BIN0;
          acc_d   = '0;
          cnt_d   = '0;
          win_d   = gnt_sel;
          last_d  = gnt_sel;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = shv[BIN_W +: BCD_W];
        sh_d  = shv[BIN_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bcd_d   = shv[BIN_W +: BCD_W];
          owner_d = win_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      bcd_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      last_q  <= last_d;
      bcd_q   <= bcd_d;
      owner_q <= owner_d;
    end
  end

  assign ACK0    = (state_q == ST_DONE) && !win_q;
  assign ACK1    = (state_q == ST_DONE) &&  win_q;
  assign BUSY    = (state_q != ST_IDLE);
  assign OWNER   = owner_q;
  assign BCD_OUT = bcd_q;

`ifdef BCD_CONV_SEG7_EN
  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_7seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    HEX_BUS = '0;
    for (int d = 0; d < DIGITS; d++) begin
      HEX_BUS[7*d +: 7] = hex_to_7seg(bcd_q[4*d +: 4]);
    end
  end
`endif

endmodule
